// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-time memory loader: loader FSM states,
// frame header length and the default data/address width.
package mem_loader_pkg;

   localparam int XLEN      = 32;
   // Header = 4-byte word count followed by 4-byte base address.
   localparam int HDR_BYTES = 8;

   typedef enum logic [2:0] {
      ST_LEN    = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DATA   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_FINISH = 3'd4,
      ST_ERR    = 3'd5
   } state_e;

endpackage

// File: rtl/mem_loader_byte_asm.sv
// Little-endian 4-byte shift assembler. Each accepted byte lands in lane
// [8k+7:8k] where k is the byte counter. word_o shows the word including the
// byte being accepted this cycle, so the owner can latch it on the 4th byte.
module byte_asm (
   input  logic        clock,
   input  logic        reset,
   input  logic        en_i,
   input  logic        clr_i,
   input  logic [7:0]  byte_i,
   output logic [1:0]  cnt_o,
   output logic [31:0] word_o,
   output logic        full_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;
   logic [31:0] word_ins;

   // Insert the incoming byte into its lane; clear on any owner state change.
   always_comb begin
      word_ins = word_q;
      if (en_i) begin
         word_ins[{cnt_q, 3'b000} +: 8] = byte_i;
      end
      cnt_d  = en_i ? cnt_q + 2'd1 : cnt_q;
      word_d = word_ins;
      if (clr_i) begin
         cnt_d  = 2'd0;
         word_d = 32'd0;
      end
   end

   // Counter and partial word hold through in_valid gaps.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q  <= 2'd0;
         word_q <= 32'd0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign word_o = word_ins;
   assign full_o = en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/mem_loader.sv
// Byte-stream frame loader: parses [N][A][N words] little-endian frames and
// issues one full-word write per payload word while holding the core in busy.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on loader state, and the source holds in_data until
// it is accepted.
module mem_loader #(
   parameter int XLEN      = mem_loader_pkg::XLEN,
   parameter int MAX_WORDS = 4096
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [7:0]      in_data,
   output logic            in_ready,
   output logic            top_mem_wen,
   output logic [XLEN-1:0] top_mem_addr,
   output logic [XLEN-1:0] top_mem_wdata,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [2:0]      dbg_state
);

   import mem_loader_pkg::*;

   localparam int CW = $clog2(MAX_WORDS + 1);

   state_e          state_q, state_d;
   logic [31:0]     len_q, len_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [CW-1:0]   wcnt_q, wcnt_d;

   logic            accept;
   logic [1:0]      asm_cnt;
   logic [31:0]     asm_word;
   logic            asm_full;

   assign accept = in_valid && in_ready;

   byte_asm u_asm (
      .clock  (clock),
      .reset  (reset),
      .en_i   (accept),
      .clr_i  (state_d != state_q),
      .byte_i (in_data),
      .cnt_o  (asm_cnt),
      .word_o (asm_word),
      .full_o (asm_full)
   );

   // Next-state, header validation and per-state outputs.
   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      addr_d        = addr_q;
      data_d        = data_q;
      wcnt_d        = wcnt_q;
      in_ready      = 1'b0;
      top_mem_wen   = 1'b0;
      top_mem_addr  = '0;
      top_mem_wdata = '0;
      done          = 1'b0;
      error         = 1'b0;
      case (state_q)
         ST_LEN: begin
            in_ready = 1'b1;
            if (asm_full) begin
               len_d   = asm_word;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            in_ready = 1'b1;
            if (asm_full) begin
               if ((len_q == 32'd0) || (len_q > 32'(MAX_WORDS)) ||
                   (asm_word[1:0] != 2'b00)) begin
                  state_d = ST_ERR;
               end else begin
                  addr_d  = XLEN'(asm_word);
                  wcnt_d  = CW'(len_q);
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            in_ready = 1'b1;
            if (asm_full) begin
               data_d  = XLEN'(asm_word);
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            top_mem_wen   = 1'b1;
            top_mem_addr  = addr_q;
            top_mem_wdata = data_q;
            addr_d        = addr_q + XLEN'(4);
            wcnt_d        = wcnt_q - CW'(1);
            state_d       = (wcnt_q == CW'(1)) ? ST_FINISH : ST_DATA;
         end
         ST_FINISH: begin
            done    = 1'b1;
            state_d = ST_LEN;
         end
         ST_ERR: begin
            error   = 1'b1;
            state_d = ST_LEN;
         end
         default: state_d = ST_LEN;
      endcase
   end

   // State and frame registers; reset discards any frame in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_LEN;
         len_q   <= 32'd0;
         addr_q  <= '0;
         data_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign busy      = (asm_cnt != 2'd0) || (state_q != ST_LEN);
   assign dbg_state = state_q;

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001: Parameter XLEN, default 32, data/address width in bits.
REQ-002: Parameter MAX_WORDS, default 4096, largest accepted payload word count.
REQ-003: clock  input  1  sole clock; all state changes on rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005: in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006: in_data  input  8  stream byte.
REQ-007: in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid && in_ready.
REQ-008: top_mem_wen  output  1  write strobe to the core's memory load port (full-word write).
REQ-009: top_mem_addr  output  XLEN  byte address of the word being written.
REQ-010: top_mem_wdata  output  XLEN  word being written.
REQ-011: busy  output  1  high from the first accepted frame byte until the frame completes or aborts; the core is stalled while high.
REQ-012: done  output  1  one-cycle pulse: frame loaded successfully.
REQ-013: error  output  1  one-cycle pulse: frame header rejected.

Function
REQ-014: Frame format is little-endian: 4 bytes word count N, then 4 bytes base address A, then 4*N payload bytes (each word little-endian).
REQ-015: States SHALL be LEN, ADDR, DATA, WRITE, FINISH, ERR; reset state LEN.
REQ-016: LEN: in_ready=1; 2-bit byte counter; each transfer shifts the byte into bits [8k+7:8k]; after the 4th byte go to ADDR.
REQ-017: ADDR: in_ready=1; same assembly; on the 4th byte, if N==0, N>MAX_WORDS, or A[1:0]!=0, go to ERR, else go to DATA with the address register = A and the word counter = N.
REQ-018: DATA: in_ready=1; assemble 4 bytes into the data register; on the 4th byte go to WRITE.
REQ-019: WRITE: exactly one cycle; in_ready=0; top_mem_wen=1, top_mem_addr=address register, top_mem_wdata=data register; on exit address += 4 (modulo 2^XLEN) and word counter -= 1; go to FINISH if the counter was 1, else DATA.
REQ-020: FINISH: one cycle; done=1, in_ready=0; go to LEN.
REQ-021: ERR: one cycle; error=1, in_ready=0; go to LEN; no memory write is issued for a rejected frame.
REQ-022: top_mem_wen SHALL be 1 only in WRITE; top_mem_addr/top_mem_wdata SHALL be 0 outside WRITE.
REQ-023: busy = 1 when the byte counter is nonzero or the state is not LEN; busy falls in the cycle after FINISH or ERR.
REQ-024: in_valid gaps SHALL stall assembly without losing the byte counter or partial word.
REQ-025: in_data is ignored whenever in_ready=0; the source holds the byte until accepted.
REQ-026: Minimum throughput is one word per 5 cycles (4 byte transfers + WRITE).
REQ-027: The byte counter resets to 0 on every state change.

Reset
REQ-028: Reset assertion SHALL asynchronously force state LEN, all counters and registers to 0, and in_ready=1, top_mem_wen=0, busy=0, done=0, error=0.
REQ-029: Reset mid-frame discards the frame; writes already issued remain in memory; a WRITE cycle cut by reset issues no partial write.
REQ-030: After deassertion the first accepted byte is the LSB of a new N.

Structure
REQ-031: A shared package holds the state enum type, the frame header length constant (8 bytes), and XLEN.
REQ-032: One sub-module, byte_asm (4-byte little-endian shift assembler with counter and full flag), is instantiated once and reused across LEN/ADDR/DATA.
REQ-033: Word counter width is $clog2(MAX_WORDS+1).

Verification
REQ-034: Frame N=2, A=0x100, words 0x00100073, 0xDEADBEEF, in_valid held high -> writes (0x100,0x00100073) then (0x104,0xDEADBEEF); done pulses in cycle 18 after the first byte; busy falls the following cycle.
REQ-035: Same frame with in_valid toggled every other cycle -> identical write sequence and data; only timing stretches.
REQ-036: N=0 -> error pulse after the 8th byte; no top_mem_wen; next byte begins a new N.
REQ-037: N=1, A=0x102 (misaligned) -> error pulse, no write; N=MAX_WORDS+1 -> error pulse.
REQ-038: Reset asserted after 2 payload bytes of frame N=3 -> all outputs at reset values immediately; a subsequent valid frame loads correctly.
REQ-039: N=1, A=0xFFFFFFFC -> single write at 0xFFFFFFFC; the address register wraps to 0 without error.
